pulse_train_analyzer: RTL and testbench
=======================================

Name: pulse_train_analyzer

Overview:
- Receive-side companion to the random pulse generator: samples a pulse stream and measures each pulse's high width and rise-to-rise period in clock cycles.
- Emits one measurement record per completed period over a valid/ready output slot.
- Keeps running statistics: pulse count, min/max width, sticky error flags.
- Sits on the tile input side; the bench feeds it the generator output to close the loop.

Parameters:
- CNT_W, 8, width of the width/period counters and record fields.
- SYNC_STAGES, 2, flops in the pulse_in synchronizer (legal 1..3).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  measurement enable.
- clear  in  1  synchronous clear of statistics, flags, FSM and output slot.
- pulse_in  in  1  pulse stream; may be asynchronous.
- m_valid  out  1  record slot holds a record.
- m_ready  in  1  consumer accepts the record when m_valid && m_ready.
- m_width  out  CNT_W  high cycles of the measured pulse.
- m_period  out  CNT_W  cycles from that pulse's rise to the next rise.
- m_sat  out  1  m_width or m_period saturated.
- pulse_count  out  16  rising edges seen; saturates at 0xFFFF.
- width_min  out  CNT_W  smallest completed width.
- width_max  out  CNT_W  largest completed width.
- overrun  out  1  sticky: a record was dropped because the slot was full.
- timeout  out  1  sticky: period counter saturated while low.

Behaviour:
- Reset (rst=1): synchronizer and edge flop cleared to 0; FSM=IDLE; width/period counters = 0.
- Reset values of outputs: m_valid=0, m_width=0, m_period=0, m_sat=0, pulse_count=0, width_min=all-ones, width_max=0, overrun=0, timeout=0.
- clear=1 does the same as reset, except the synchronizer chain keeps sampling. rst has priority over clear.
- Synchronizer: s = pulse_in delayed by SYNC_STAGES flops; s_d is s delayed one more cycle.
- Edges: rise = s & ~s_d; fall = ~s & s_d.
- FSM states are IDLE, HIGH and LOW.
- IDLE: on rise, go to HIGH; width_cnt<=1; period_cnt<=1; no record is emitted (no prior period).
- HIGH: width_cnt and period_cnt increment each cycle, saturating at 2^CNT_W-1. On fall, go to LOW and update width_min/width_max with width_cnt.
- LOW: period_cnt increments (saturating). On rise: emit record {width_cnt, period_cnt, sat}; reload both counters to 1; pulse_count++; go to HIGH.
- LOW timeout: if period_cnt reaches all-ones while still low, go to IDLE, set timeout, emit no record.
- pulse_count increments on every rise, including the IDLE rise.
- Saturation: a field reaching all-ones while still counting sets a per-pulse sat bit; m_sat carries that bit.
- Latency: the first clk edge that samples pulse_in=1 is edge 0. rise is seen SYNC_STAGES edges later. A record launched by that rise has m_valid=1 after edge SYNC_STAGES+1.
- Output slot (one entry):
  - Load when empty, or when m_valid && m_ready in the same cycle as a new record; m_valid stays 1 in that case.
  - New record while m_valid && !m_ready: drop the new record, keep the old one, set overrun.
  - Fields are stable while m_valid && !m_ready.
- ena=0: FSM forced to IDLE next cycle. Counters and statistics hold; no records are generated; the output slot handshake still operates. A pulse in progress at deassertion is discarded.
- Back-to-back rise and fall are impossible after the edge flop; a one-cycle pulse gives width=1.

Test Plan:
- Reset, then clear-to-reset comparison -> after rst: m_valid=0, width_min=0xFF, width_max=0, pulse_count=0, flags 0. Repeat with clear=1 (no rst) -> identical output values.
- Periodic input, 3 high / 5 low, m_ready=1 -> first record width=3, period=8, m_sat=0. m_valid rises 3 cycles after pulse_in first sampled high (SYNC_STAGES=2). After 4 pulses: pulse_count=4, width_min=width_max=3.
- Mixed widths 1, 4, 2 with 6-cycle gaps -> records (1,7), (4,10). width_min=1, width_max=4 once the third pulse has fallen.
- m_ready=0 during two complete periods -> first record held with stable fields, second dropped, overrun=1. m_ready=1 -> first record accepted, m_valid=0.
- pulse_in high for 300 cycles, then low 2, then high -> record width=255, period=255, m_sat=1.
- pulse_in stuck low 260 cycles after one pulse -> timeout=1, FSM in IDLE, no record. The next rise emits no record; pulse_count still increments.
- rst=1 in the middle of a HIGH phase -> all outputs at reset values next cycle. No record from the interrupted pulse.

Source files
------------

// File: rtl/pulse_train_analyzer.sv
// pulse_train_analyzer
//   Samples a (possibly asynchronous) pulse stream and measures each pulse's
//   high width and rise-to-rise period in clock cycles. One record is emitted
//   per completed period through a single-entry valid/ready slot. Running
//   statistics: pulse count, min/max width, sticky overrun and timeout flags.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (priority over clear)
//   ena          measurement enable; low forces the FSM to idle
//   clear        synchronous clear of everything except the synchronizer chain
//   pulse_in     pulse stream input
//   m_valid      record slot occupied
//   m_ready      consumer accepts record when m_valid && m_ready
//   m_width      high cycles of the measured pulse
//   m_period     cycles from that pulse's rise to the next rise
//   m_sat        width or period saturated during that pulse
//   pulse_count  rising edges seen (saturating)
//   width_min    smallest completed width (all-ones when none yet)
//   width_max    largest completed width
//   overrun      sticky: record dropped because the slot was full
//   timeout      sticky: period counter saturated while low
module pulse_train_analyzer #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             clear,
   input  logic             pulse_in,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] m_width,
   output logic [CNT_W-1:0] m_period,
   output logic             m_sat,
   output logic [15:0]      pulse_count,
   output logic [CNT_W-1:0] width_min,
   output logic [CNT_W-1:0] width_max,
   output logic             overrun,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] MAX    = '1;
   localparam logic [CNT_W-1:0] MAX_M1 = MAX - 1'b1;
   localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StHigh, StLow} state_t;

   // Synchronizer and edge detection
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   w_s;
   logic                   w_rise;
   logic                   w_fall;

   // Measurement state
   state_t           r_state;
   logic [CNT_W-1:0] r_width_cnt;
   logic [CNT_W-1:0] r_period_cnt;
   logic             r_sat;
   logic [15:0]      r_pulse_count;
   logic [CNT_W-1:0] r_width_min;
   logic [CNT_W-1:0] r_width_max;
   logic             r_timeout;

   // Record launch stage between the FSM and the output slot
   logic             r_rec_vld;
   logic [CNT_W-1:0] r_rec_width;
   logic [CNT_W-1:0] r_rec_period;
   logic             r_rec_sat;

   // Output slot
   logic             r_m_valid;
   logic [CNT_W-1:0] r_m_width;
   logic [CNT_W-1:0] r_m_period;
   logic             r_m_sat;
   logic             r_overrun;

   logic [CNT_W-1:0] w_width_inc;
   logic [CNT_W-1:0] w_period_inc;
   logic             w_width_hit;
   logic             w_period_hit;

   assign w_s    = r_sync[SYNC_STAGES-1];
   assign w_rise = w_s & ~r_s_d;
   assign w_fall = ~w_s & r_s_d;

   // Saturating increments; *_hit flags the increment that lands on all-ones
   assign w_width_inc  = (r_width_cnt == MAX) ? MAX : r_width_cnt + 1'b1;
   assign w_period_inc = (r_period_cnt == MAX) ? MAX : r_period_cnt + 1'b1;
   assign w_width_hit  = (r_width_cnt == MAX_M1);
   assign w_period_hit = (r_period_cnt == MAX_M1);

   // Synchronizer keeps sampling through clear so the input view stays live
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync[0] <= pulse_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_s_d <= 1'b0;
      end else begin
         r_s_d <= w_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state       <= StIdle;
         r_width_cnt   <= '0;
         r_period_cnt  <= '0;
         r_sat         <= 1'b0;
         r_pulse_count <= '0;
         r_width_min   <= MAX;
         r_width_max   <= '0;
         r_timeout     <= 1'b0;
         r_rec_vld     <= 1'b0;
         r_rec_width   <= '0;
         r_rec_period  <= '0;
         r_rec_sat     <= 1'b0;
      end else begin
         r_rec_vld <= 1'b0;
         if (!ena) begin
            // Abandon any pulse in progress; counters and statistics hold
            r_state <= StIdle;
         end else begin
            if (w_rise && (r_pulse_count != 16'hFFFF)) begin
               r_pulse_count <= r_pulse_count + 16'd1;
            end
            unique case (r_state)
               StIdle: begin
                  // First rise has no prior period, so no record
                  if (w_rise) begin
                     r_state      <= StHigh;
                     r_width_cnt  <= ONE;
                     r_period_cnt <= ONE;
                     r_sat        <= 1'b0;
                  end
               end
               StHigh: begin
                  if (w_fall) begin
                     r_state      <= StLow;
                     r_period_cnt <= w_period_inc;
                     if (w_period_hit) r_sat <= 1'b1;
                     if (r_width_cnt < r_width_min) r_width_min <= r_width_cnt;
                     if (r_width_cnt > r_width_max) r_width_max <= r_width_cnt;
                  end else begin
                     r_width_cnt  <= w_width_inc;
                     r_period_cnt <= w_period_inc;
                     if (w_width_hit || w_period_hit) r_sat <= 1'b1;
                  end
               end
               StLow: begin
                  if (w_rise) begin
                     r_rec_vld    <= 1'b1;
                     r_rec_width  <= r_width_cnt;
                     r_rec_period <= r_period_cnt;
                     r_rec_sat    <= r_sat;
                     r_width_cnt  <= ONE;
                     r_period_cnt <= ONE;
                     r_sat        <= 1'b0;
                     r_state      <= StHigh;
                  end else if (w_period_hit) begin
                     // Period ran out while low: give up on this pulse
                     r_period_cnt <= MAX;
                     r_timeout    <= 1'b1;
                     r_state      <= StIdle;
                  end else begin
                     // A period already saturated during the high phase holds
                     r_period_cnt <= w_period_inc;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // Single-entry output slot; a full, stalled slot drops the newcomer
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_m_valid  <= 1'b0;
         r_m_width  <= '0;
         r_m_period <= '0;
         r_m_sat    <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (r_rec_vld) begin
         if (!r_m_valid || m_ready) begin
            r_m_valid  <= 1'b1;
            r_m_width  <= r_rec_width;
            r_m_period <= r_rec_period;
            r_m_sat    <= r_rec_sat;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_m_valid && m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign m_valid     = r_m_valid;
   assign m_width     = r_m_width;
   assign m_period    = r_m_period;
   assign m_sat       = r_m_sat;
   assign pulse_count = r_pulse_count;
   assign width_min   = r_width_min;
   assign width_max   = r_width_max;
   assign overrun     = r_overrun;
   assign timeout     = r_timeout;

endmodule

// File: tb/tb_pulse_train_analyzer.sv
// tb_pulse_train_analyzer
//   Drives pulse trains into pulse_train_analyzer (CNT_W=8, SYNC_STAGES=2).
//   Expected records are queued when the next rise is driven and compared when
//   the DUT hands them over; statistics and flags are compared inline.
module tb_pulse_train_analyzer;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned SYNC  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             ena;
   logic             clear;
   logic             pulse_in;
   logic             m_ready;
   logic             m_valid;
   logic [CNT_W-1:0] m_width;
   logic [CNT_W-1:0] m_period;
   logic             m_sat;
   logic [15:0]      pulse_count;
   logic [CNT_W-1:0] width_min;
   logic [CNT_W-1:0] width_max;
   logic             overrun;
   logic             timeout;

   pulse_train_analyzer #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .clear       (clear),
      .pulse_in    (pulse_in),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_width     (m_width),
      .m_period    (m_period),
      .m_sat       (m_sat),
      .pulse_count (pulse_count),
      .width_min   (width_min),
      .width_max   (width_max),
      .overrun     (overrun),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int high;
      int low;
      int exp_w;
      int exp_p;
      bit exp_sat;
   } vec_t;

   typedef struct {
      int w;
      int p;
      bit sat;
   } rec_t;

   vec_t vecs[7];
   rec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         pulse_in = v;
         tick();
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_m_valid"}, m_valid, 0);
      check({pfx, "_m_width"}, m_width, 0);
      check({pfx, "_m_period"}, m_period, 0);
      check({pfx, "_m_sat"}, m_sat, 0);
      check({pfx, "_pulse_count"}, pulse_count, 0);
      check({pfx, "_width_min"}, width_min, 255);
      check({pfx, "_width_max"}, width_max, 0);
      check({pfx, "_overrun"}, overrun, 0);
      check({pfx, "_timeout"}, timeout, 0);
   endtask

   // Scoreboard: compare every accepted record against the queued expectation
   always @(negedge clk) begin
      rec_t e;
      if (m_valid && m_ready) begin
         if (sb.size() == 0) begin
            check("record_expected", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            check("rec_width", m_width, e.w);
            check("rec_period", m_period, e.p);
            check("rec_sat", m_sat, int'(e.sat));
         end
      end
   end

   initial begin
      // Periodic 3/5 train, then mixed widths 1, 4, 2 with 6-cycle gaps
      for (int i = 0; i < 4; i++) vecs[i] = '{3, 5, 3, 8, 1'b0};
      vecs[4] = '{1, 6, 1, 7, 1'b0};
      vecs[5] = '{4, 6, 4, 10, 1'b0};
      vecs[6] = '{2, 6, 2, 8, 1'b0};

      rst      = 1'b1;
      ena      = 1'b1;
      clear    = 1'b0;
      pulse_in = 1'b0;
      m_ready  = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_reset("rst");

      for (int i = 0; i < 7; i++) begin
         if (i > 0) sb.push_back('{vecs[i-1].exp_w, vecs[i-1].exp_p, vecs[i-1].exp_sat});
         for (int e = 0; e < vecs[i].high + vecs[i].low; e++) begin
            pulse_in = (e < vecs[i].high);
            tick();
            // Edge e has just happened; record from this rise lands after edge SYNC+1
            if (i == 1 && e == SYNC) check("latency_before", m_valid, 0);
            if (i == 1 && e == SYNC + 1) check("latency_at", m_valid, 1);
         end
         if (i == 3) begin
            check("periodic_pulse_count", pulse_count, 4);
            check("periodic_width_min", width_min, 3);
            check("periodic_width_max", width_max, 3);
         end
         if (i == 6) begin
            check("mixed_pulse_count", pulse_count, 7);
            check("mixed_width_min", width_min, 1);
            check("mixed_width_max", width_max, 4);
         end
      end

      // Stalled consumer across two rises: first record held, second dropped
      m_ready = 1'b0;
      sb.push_back('{vecs[6].exp_w, vecs[6].exp_p, vecs[6].exp_sat});
      drive(1'b1, 3);
      drive(1'b0, 5);
      check("held_a_valid", m_valid, 1);
      check("held_a_width", m_width, 2);
      check("held_a_period", m_period, 8);
      check("held_a_overrun", overrun, 0);
      drive(1'b1, 3);
      drive(1'b0, 5);
      check("held_b_valid", m_valid, 1);
      check("held_b_width", m_width, 2);
      check("held_b_period", m_period, 8);
      check("held_b_overrun", overrun, 1);
      m_ready = 1'b1;
      tick();
      check("accept_valid", m_valid, 0);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_reset("clear");

      // Long pulse saturates both fields
      drive(1'b1, 300);
      drive(1'b0, 2);
      sb.push_back('{255, 255, 1'b1});
      drive(1'b1, 2);
      // Stuck low: period runs out, no record
      drive(1'b0, 260);
      check("timeout_flag", timeout, 1);
      check("timeout_pulse_count", pulse_count, 2);
      check("timeout_no_record", m_valid, 0);

      // Rise from idle after timeout counts but emits nothing; reset mid-high
      drive(1'b1, 10);
      check("post_timeout_pulse_count", pulse_count, 3);
      check("post_timeout_no_record", m_valid, 0);
      check("post_timeout_flag_sticky", timeout, 1);
      pulse_in = 1'b0;
      rst      = 1'b1;
      tick();
      check_reset("rst_mid_high");
      rst = 1'b0;
      drive(1'b0, 20);
      check("after_rst_no_record", m_valid, 0);
      check("after_rst_pulse_count", pulse_count, 0);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
